dcm: RTL and testbench
======================

# dcm

Discard control module: the stage directly downstream of the statistics/marking stage in the MD/PHV pipeline. It buffers MD/PHV pairs and drops pairs addressed to it whose MD discard flag (bit 108) is set. Surviving pairs are forwarded with the next-module ID rewritten. It also counts drops and forwards, and exposes those counters on the 134-bit configuration packet chain.

## Interface
- LMID, 8'd5: local module ID matched against MD[87:80].
- NMID, 8'd6: next module ID written into MD[87:80] of forwarded local pairs.
- ALF_THRESH, 8'd250: FIFO used-words level above which almost-full is raised.
- clk  in  1  clock.
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk.
- in_dcm_md / in_dcm_md_wr  in  256 / 1  metadata from upstream.
- out_dcm_md_alf  out  1  MD almost-full to upstream.
- in_dcm_phv / in_dcm_phv_wr  in  1024 / 1  PHV from upstream.
- out_dcm_phv_alf  out  1  PHV almost-full to upstream.
- out_dcm_md / out_dcm_md_wr  out  256 / 1  metadata to downstream.
- in_dcm_md_alf  in  1  downstream MD almost-full.
- out_dcm_phv / out_dcm_phv_wr  out  1024 / 1  PHV to downstream.
- in_dcm_phv_alf  in  1  downstream PHV almost-full.
- cin_dcm_data / cin_dcm_data_wr  in  134 / 1  config packet input.
- cout_dcm_ready  out  1  config ready upstream; equals cin_dcm_ready combinationally.
- cout_dcm_data / cout_dcm_data_wr  out  134 / 1  config packet output.
- cin_dcm_ready  in  1  downstream config ready.

## Operation
- Two 256-deep show-ahead FIFOs, MD and PHV, both written directly by their *_wr strobes.
- out_dcm_md_alf = in_dcm_md_alf | (md_usedw > ALF_THRESH); out_dcm_phv_alf = in_dcm_phv_alf | (phv_usedw > ALF_THRESH).
- FSM IDLE/SEND:
  - IDLE: when both FIFOs are non-empty and in_dcm_md_alf = in_dcm_phv_alf = 0, capture both head words and the decision, then go to SEND. If only one FIFO is non-empty, wait.
  - SEND: rd_en of both FIFOs = 1 (combinational, state==SEND). Then return to IDLE.
- Decision, made on the captured MD:
  - If MD[87:80] != LMID: bypass unchanged.
  - If MD[87:80] == LMID, MD[108]=1 and ctrl.drop_en=1: drop. No output write; drop_pkt_cnt+1; drop_byte_cnt += zero-extended MD[107:96].
  - Otherwise: forward with MD[87:80]=NMID and all other bits unchanged; fwd_pkt_cnt+1. Bypassed pairs also count into fwd_pkt_cnt.
- Config access applies only when cin_dcm_data_wr=1 and cin_dcm_ready=1. Address is [95:64]; type is [126:124]: 3'b010 write, 3'b011 read.
- Registers:
  - 0x71000000 ctrl: bit0 clear (self-clearing), bit1 drop_en (reset 1).
  - 0x71000008/9 drop_pkt_cnt lo/hi.
  - 0x7100000A/B drop_byte_cnt lo/hi.
  - 0x7100000C/D fwd_pkt_cnt lo/hi.
- Read response: cout_dcm_data = {cin[133:128], 4'b1011, cin[123:32], data32}. A read of an unmapped address returns data32 = 0.
- All other config words, including writes, pass through unchanged.
- Counters are 64-bit and wrap. A clear in the same cycle as an increment: clear wins, and the counter is 0 on the next cycle.

## Timing
- Reset values:
  - Outputs: out_dcm_md=0, out_dcm_phv=0, all *_wr=0, cout_dcm_data=0.
  - Internal: counters 0, drop_en=1, FSM in IDLE, FIFOs flushed (srst=!rst_n).
- Latency: a pair at the FIFO head with no backpressure at edge N gives out_*_wr=1 at edge N+2. Throughput is one pair per 2 cycles.
- out_dcm_md_wr and out_dcm_phv_wr are single-cycle pulses, always asserted together.
- Config path: 1-cycle registered latency; cout_dcm_data_wr = registered cin_dcm_data_wr & cin_dcm_ready.
- Backpressure is sampled only in IDLE. A pair already in SEND completes.
- Reset mid-SEND: the pair is lost and both FIFOs are flushed, so MD and PHV stay aligned.

## Configuration
- DCM_STATS_EN defined: the three 64-bit counters, the clear bit and their read addresses exist.
- DCM_STATS_EN undefined: counters are not built; reads of 0x71000008–D return 0; drop behaviour and ctrl.drop_en are unchanged.

## Structure
- Shared package: config type codes (WR=3'b010, RD=3'b011, RESP=4'b1011), register address constants, MD field positions (ID 87:80, LEN 107:96, DISCARD 108), FSM state enum.
- One natural sub-module: dcm_cfg_regs. It handles config decode, the ctrl register, the counters and read-response muxing; the FSM supplies its increment strobes.
- FIFOs reuse the existing fifo_256_256 and fifo_1024_256 IP.

## Test plan
- Bypass: MD[87:80]=8'd3 with PHV=1024'hA5 -> identical MD/PHV out 2 cycles after becoming available; fwd_pkt_cnt=1.
- Forward rewrite: MD[87:80]=5, MD[108]=0 -> output MD[87:80]=6, other bits equal.
- Drop: 3 pairs with ID=5, MD[108]=1, LEN=12'd100 -> no output writes; reading 0x71000008 gives 3; reading 0x7100000A gives 300.
- drop_en=0 (write 0x71000000 data 0): flagged pair forwarded with ID=6 and bit108=1; drop counters unchanged.
- Backpressure: hold in_dcm_md_alf=1 with 5 pairs queued -> zero output writes; release -> 5 writes spaced 2 cycles apart; push 251 MD words -> out_dcm_md_alf=1.
- Clear coincident with a drop -> drop_pkt_cnt reads 0; an unmapped-address config word passes through unchanged after 1 cycle.

Source files
------------

// File: rtl/dcm_pkg.sv
// Shared definitions for the discard control module: config word fields,
// register map, MD field positions and the pair-forwarding FSM states.
package dcm_pkg;

   localparam logic [2:0] CFG_WR   = 3'b010;
   localparam logic [2:0] CFG_RD   = 3'b011;
   localparam logic [3:0] CFG_RESP = 4'b1011;

   localparam int CFG_TYPE_HI = 126;
   localparam int CFG_TYPE_LO = 124;
   localparam int CFG_ADDR_HI = 95;
   localparam int CFG_ADDR_LO = 64;

   localparam logic [31:0] ADDR_CTRL          = 32'h7100_0000;
   localparam logic [31:0] ADDR_DROP_PKT_LO   = 32'h7100_0008;
   localparam logic [31:0] ADDR_DROP_PKT_HI   = 32'h7100_0009;
   localparam logic [31:0] ADDR_DROP_BYTE_LO  = 32'h7100_000A;
   localparam logic [31:0] ADDR_DROP_BYTE_HI  = 32'h7100_000B;
   localparam logic [31:0] ADDR_FWD_PKT_LO    = 32'h7100_000C;
   localparam logic [31:0] ADDR_FWD_PKT_HI    = 32'h7100_000D;

   localparam int CTRL_CLEAR_BIT   = 0;
   localparam int CTRL_DROP_EN_BIT = 1;

   localparam int MD_ID_HI    = 87;
   localparam int MD_ID_LO    = 80;
   localparam int MD_LEN_HI   = 107;
   localparam int MD_LEN_LO   = 96;
   localparam int MD_DISCARD  = 108;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } dcm_state_e;

endpackage

// File: rtl/dcm_cfg_regs.sv
// Config-chain decode for dcm: ctrl register, drop/forward statistics and
// read responses. Statistics are only built when DCM_STATS_EN is defined.
module dcm_cfg_regs
   import dcm_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [133:0] cin_dcm_data,
   input  logic         cin_dcm_data_wr,
   input  logic         cin_dcm_ready,
   input  logic         drop_inc,
   input  logic         fwd_inc,
   input  logic [11:0]  drop_len,
   output logic         drop_en,
   output logic [133:0] cout_dcm_data,
   output logic         cout_dcm_data_wr
);

   logic         cfg_fire, is_rd, ctrl_wr;
   logic [2:0]   cfg_type;
   logic [31:0]  cfg_addr, rd_data;
   logic         drop_en_q, drop_en_d;
   logic [133:0] cout_data_q, cout_data_d;
   logic         cout_wr_q, cout_wr_d;

`ifdef DCM_STATS_EN
   logic [63:0] drop_pkt_q, drop_pkt_d;
   logic [63:0] drop_byte_q, drop_byte_d;
   logic [63:0] fwd_pkt_q, fwd_pkt_d;
   logic        stats_clear;

   // Clear has priority over a same-cycle increment so software sees a clean zero.
   always_comb begin
      stats_clear = ctrl_wr && cin_dcm_data[CTRL_CLEAR_BIT];
      drop_pkt_d  = drop_pkt_q + 64'(drop_inc);
      drop_byte_d = drop_inc ? drop_byte_q + {52'd0, drop_len} : drop_byte_q;
      fwd_pkt_d   = fwd_pkt_q + 64'(fwd_inc);
      if (stats_clear) begin
         drop_pkt_d  = '0;
         drop_byte_d = '0;
         fwd_pkt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_pkt_q  <= '0;
         drop_byte_q <= '0;
         fwd_pkt_q   <= '0;
      end else begin
         drop_pkt_q  <= drop_pkt_d;
         drop_byte_q <= drop_byte_d;
         fwd_pkt_q   <= fwd_pkt_d;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = ^{drop_inc, fwd_inc, drop_len};
`endif

   always_comb begin
      cfg_fire  = cin_dcm_data_wr && cin_dcm_ready;
      cfg_type  = cin_dcm_data[CFG_TYPE_HI:CFG_TYPE_LO];
      cfg_addr  = cin_dcm_data[CFG_ADDR_HI:CFG_ADDR_LO];
      is_rd     = cfg_fire && (cfg_type == CFG_RD);
      ctrl_wr   = cfg_fire && (cfg_type == CFG_WR) && (cfg_addr == ADDR_CTRL);
      drop_en_d = ctrl_wr ? cin_dcm_data[CTRL_DROP_EN_BIT] : drop_en_q;
   end

   always_comb begin
      rd_data = '0;
      case (cfg_addr)
         ADDR_CTRL:         rd_data = {30'd0, drop_en_q, 1'b0};
`ifdef DCM_STATS_EN
         ADDR_DROP_PKT_LO:  rd_data = drop_pkt_q[31:0];
         ADDR_DROP_PKT_HI:  rd_data = drop_pkt_q[63:32];
         ADDR_DROP_BYTE_LO: rd_data = drop_byte_q[31:0];
         ADDR_DROP_BYTE_HI: rd_data = drop_byte_q[63:32];
         ADDR_FWD_PKT_LO:   rd_data = fwd_pkt_q[31:0];
         ADDR_FWD_PKT_HI:   rd_data = fwd_pkt_q[63:32];
`endif
         default:           rd_data = '0;
      endcase
   end

   always_comb begin
      cout_wr_d   = cfg_fire;
      cout_data_d = cout_data_q;
      if (is_rd) begin
         cout_data_d = {cin_dcm_data[133:128], CFG_RESP, cin_dcm_data[123:32], rd_data};
      end else if (cfg_fire) begin
         cout_data_d = cin_dcm_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_en_q   <= 1'b1;
         cout_data_q <= '0;
         cout_wr_q   <= 1'b0;
      end else begin
         drop_en_q   <= drop_en_d;
         cout_data_q <= cout_data_d;
         cout_wr_q   <= cout_wr_d;
      end
   end

   assign drop_en          = drop_en_q;
   assign cout_dcm_data    = cout_data_q;
   assign cout_dcm_data_wr = cout_wr_q;

endmodule

// File: rtl/fifo_1024_256.sv
// 256-deep, 1024-bit show-ahead FIFO for PHVs; same behaviour as fifo_256_256.
module fifo_1024_256 (
   input  logic          clk,
   input  logic          srst,
   input  logic [1023:0] data,
   input  logic          wrreq,
   input  logic          rdreq,
   output logic [1023:0] q,
   output logic          empty,
   output logic [8:0]    usedw
);

   logic [1023:0] mem_q [256];
   logic [7:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [8:0]    cnt_q, cnt_d;
   logic          do_wr, do_rd;

   always_comb begin
      do_wr    = wrreq && (cnt_q != 9'd256);
      do_rd    = rdreq && (cnt_q != 9'd0);
      wr_ptr_d = wr_ptr_q + 8'(do_wr);
      rd_ptr_d = rd_ptr_q + 8'(do_rd);
      cnt_d    = cnt_q + 9'(do_wr) - 9'(do_rd);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= data;
   end

   assign q     = mem_q[rd_ptr_q];
   assign empty = (cnt_q == 9'd0);
   assign usedw = cnt_q;

endmodule

// File: rtl/fifo_256_256.sv
// 256-deep, 256-bit show-ahead FIFO: q always presents the head word,
// rdreq pops it. Writes when full and reads when empty are ignored.
module fifo_256_256 (
   input  logic         clk,
   input  logic         srst,
   input  logic [255:0] data,
   input  logic         wrreq,
   input  logic         rdreq,
   output logic [255:0] q,
   output logic         empty,
   output logic [8:0]   usedw
);

   logic [255:0] mem_q [256];
   logic [7:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [8:0]   cnt_q, cnt_d;
   logic         do_wr, do_rd;

   always_comb begin
      do_wr    = wrreq && (cnt_q != 9'd256);
      do_rd    = rdreq && (cnt_q != 9'd0);
      wr_ptr_d = wr_ptr_q + 8'(do_wr);
      rd_ptr_d = rd_ptr_q + 8'(do_rd);
      cnt_d    = cnt_q + 9'(do_wr) - 9'(do_rd);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= data;
   end

   assign q     = mem_q[rd_ptr_q];
   assign empty = (cnt_q == 9'd0);
   assign usedw = cnt_q;

endmodule

// File: rtl/dcm.sv
// Discard control module: buffers MD/PHV pairs, drops flagged local pairs and
// forwards the rest with the next-module ID. Optional statistics: DCM_STATS_EN.
module dcm
   import dcm_pkg::*;
#(
   parameter logic [7:0] LMID       = 8'd5,
   parameter logic [7:0] NMID       = 8'd6,
   parameter logic [7:0] ALF_THRESH = 8'd250
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [255:0]  in_dcm_md,
   input  logic          in_dcm_md_wr,
   output logic          out_dcm_md_alf,
   input  logic [1023:0] in_dcm_phv,
   input  logic          in_dcm_phv_wr,
   output logic          out_dcm_phv_alf,
   output logic [255:0]  out_dcm_md,
   output logic          out_dcm_md_wr,
   input  logic          in_dcm_md_alf,
   output logic [1023:0] out_dcm_phv,
   output logic          out_dcm_phv_wr,
   input  logic          in_dcm_phv_alf,
   input  logic [133:0]  cin_dcm_data,
   input  logic          cin_dcm_data_wr,
   output logic          cout_dcm_ready,
   output logic [133:0]  cout_dcm_data,
   output logic          cout_dcm_data_wr,
   input  logic          cin_dcm_ready
);

   logic [255:0]  md_head;
   logic [1023:0] phv_head;
   logic          md_empty, phv_empty;
   logic [8:0]    md_usedw, phv_usedw;
   logic          fifo_srst, fifo_rd, pair_ready, capture;
   logic          drop_inc, fwd_inc, drop_en, head_local;

   dcm_state_e    state_q, state_d;
   logic [255:0]  md_buf_q, md_buf_d;
   logic [1023:0] phv_buf_q, phv_buf_d;
   logic          drop_q, drop_d;
   logic [11:0]   len_q, len_d;
   logic [255:0]  out_md_q, out_md_d;
   logic [1023:0] out_phv_q, out_phv_d;
   logic          out_wr_q, out_wr_d;

   // Both FIFOs share one flush so MD and PHV can never drift out of step.
   assign fifo_srst = !rst_n;

   fifo_256_256 u_md_fifo (
      .clk   (clk),
      .srst  (fifo_srst),
      .data  (in_dcm_md),
      .wrreq (in_dcm_md_wr),
      .rdreq (fifo_rd),
      .q     (md_head),
      .empty (md_empty),
      .usedw (md_usedw)
   );

   fifo_1024_256 u_phv_fifo (
      .clk   (clk),
      .srst  (fifo_srst),
      .data  (in_dcm_phv),
      .wrreq (in_dcm_phv_wr),
      .rdreq (fifo_rd),
      .q     (phv_head),
      .empty (phv_empty),
      .usedw (phv_usedw)
   );

   assign out_dcm_md_alf  = in_dcm_md_alf  | (md_usedw  > {1'b0, ALF_THRESH});
   assign out_dcm_phv_alf = in_dcm_phv_alf | (phv_usedw > {1'b0, ALF_THRESH});
   assign pair_ready      = !md_empty && !phv_empty && !in_dcm_md_alf && !in_dcm_phv_alf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pair_ready) state_d = ST_SEND;
         ST_SEND: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      capture  = (state_q == ST_IDLE) && pair_ready;
      fifo_rd  = (state_q == ST_SEND);
      drop_inc = fifo_rd && drop_q;
      fwd_inc  = fifo_rd && !drop_q;
   end

   // The drop decision uses drop_en as it stands when the pair is captured.
   always_comb begin
      head_local = (md_head[MD_ID_HI:MD_ID_LO] == LMID);
      md_buf_d   = md_buf_q;
      phv_buf_d  = phv_buf_q;
      drop_d     = drop_q;
      len_d      = len_q;
      if (capture) begin
         md_buf_d  = md_head;
         phv_buf_d = phv_head;
         drop_d    = head_local && md_head[MD_DISCARD] && drop_en;
         len_d     = md_head[MD_LEN_HI:MD_LEN_LO];
         if (head_local) md_buf_d[MD_ID_HI:MD_ID_LO] = NMID;
      end
      out_wr_d  = fwd_inc;
      out_md_d  = fwd_inc ? md_buf_q  : out_md_q;
      out_phv_d = fwd_inc ? phv_buf_q : out_phv_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_buf_q  <= '0;
         phv_buf_q <= '0;
         drop_q    <= 1'b0;
         len_q     <= '0;
         out_md_q  <= '0;
         out_phv_q <= '0;
         out_wr_q  <= 1'b0;
      end else begin
         md_buf_q  <= md_buf_d;
         phv_buf_q <= phv_buf_d;
         drop_q    <= drop_d;
         len_q     <= len_d;
         out_md_q  <= out_md_d;
         out_phv_q <= out_phv_d;
         out_wr_q  <= out_wr_d;
      end
   end

   dcm_cfg_regs u_cfg_regs (
      .clk              (clk),
      .rst_n            (rst_n),
      .cin_dcm_data     (cin_dcm_data),
      .cin_dcm_data_wr  (cin_dcm_data_wr),
      .cin_dcm_ready    (cin_dcm_ready),
      .drop_inc         (drop_inc),
      .fwd_inc          (fwd_inc),
      .drop_len         (len_q),
      .drop_en          (drop_en),
      .cout_dcm_data    (cout_dcm_data),
      .cout_dcm_data_wr (cout_dcm_data_wr)
   );

   assign cout_dcm_ready = cin_dcm_ready;
   assign out_dcm_md     = out_md_q;
   assign out_dcm_phv    = out_phv_q;
   assign out_dcm_md_wr  = out_wr_q;
   assign out_dcm_phv_wr = out_wr_q;

endmodule

// File: tb/tb_dcm.sv
// Self-checking bench for dcm: scoreboard queues fed by the stimulus tasks,
// a negedge monitor that pops and compares, and a plain behavioural model.
module tb_dcm;

   localparam logic [31:0] A_CTRL  = 32'h7100_0000;
   localparam logic [31:0] A_DPLO  = 32'h7100_0008;
   localparam logic [31:0] A_DPHI  = 32'h7100_0009;
   localparam logic [31:0] A_DBLO  = 32'h7100_000A;
   localparam logic [31:0] A_DBHI  = 32'h7100_000B;
   localparam logic [31:0] A_FPLO  = 32'h7100_000C;
   localparam logic [31:0] A_FPHI  = 32'h7100_000D;
   localparam logic [2:0]  T_WR    = 3'b010;
   localparam logic [2:0]  T_RD    = 3'b011;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [255:0]  in_dcm_md;
   logic          in_dcm_md_wr;
   logic          out_dcm_md_alf;
   logic [1023:0] in_dcm_phv;
   logic          in_dcm_phv_wr;
   logic          out_dcm_phv_alf;
   logic [255:0]  out_dcm_md;
   logic          out_dcm_md_wr;
   logic          in_dcm_md_alf;
   logic [1023:0] out_dcm_phv;
   logic          out_dcm_phv_wr;
   logic          in_dcm_phv_alf;
   logic [133:0]  cin_dcm_data;
   logic          cin_dcm_data_wr;
   logic          cout_dcm_ready;
   logic [133:0]  cout_dcm_data;
   logic          cout_dcm_data_wr;
   logic          cin_dcm_ready;

   dcm dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_dcm_md        (in_dcm_md),
      .in_dcm_md_wr     (in_dcm_md_wr),
      .out_dcm_md_alf   (out_dcm_md_alf),
      .in_dcm_phv       (in_dcm_phv),
      .in_dcm_phv_wr    (in_dcm_phv_wr),
      .out_dcm_phv_alf  (out_dcm_phv_alf),
      .out_dcm_md       (out_dcm_md),
      .out_dcm_md_wr    (out_dcm_md_wr),
      .in_dcm_md_alf    (in_dcm_md_alf),
      .out_dcm_phv      (out_dcm_phv),
      .out_dcm_phv_wr   (out_dcm_phv_wr),
      .in_dcm_phv_alf   (in_dcm_phv_alf),
      .cin_dcm_data     (cin_dcm_data),
      .cin_dcm_data_wr  (cin_dcm_data_wr),
      .cout_dcm_ready   (cout_dcm_ready),
      .cout_dcm_data    (cout_dcm_data),
      .cout_dcm_data_wr (cout_dcm_data_wr),
      .cin_dcm_ready    (cin_dcm_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0]  md;
      logic [1023:0] phv;
   } pair_t;

   int           checks = 0;
   int           errors = 0;
   pair_t        exp_pairs[$];
   logic [133:0] exp_cfg[$];
   pair_t        mon_pair;
   logic [133:0] mon_cfg;

   // Behavioural model state: what software would believe about the block.
   logic         m_drop_en;
   logic [63:0]  m_drop_pkt, m_drop_byte, m_fwd_pkt;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [1023:0] randPhv();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [255:0] makeMd(input logic [7:0] id, input logic discard, input logic [11:0] len);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      r[87:80]  = id;
      r[108]    = discard;
      r[107:96] = len;
      return r;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      logic [31:0] r;
      r = 32'd0;
      if (addr == A_CTRL) r = {30'd0, m_drop_en, 1'b0};
`ifdef DCM_STATS_EN
      if (addr == A_DPLO) r = m_drop_pkt[31:0];
      if (addr == A_DPHI) r = m_drop_pkt[63:32];
      if (addr == A_DBLO) r = m_drop_byte[31:0];
      if (addr == A_DBHI) r = m_drop_byte[63:32];
      if (addr == A_FPLO) r = m_fwd_pkt[31:0];
      if (addr == A_FPHI) r = m_fwd_pkt[63:32];
`endif
      return r;
   endfunction

   // Push one MD/PHV pair; the model decides its fate and queues any output.
   task automatic applyStimulus(input logic [255:0] md, input logic [1023:0] phv);
      pair_t p;
      logic  local_id;
      local_id = (md[87:80] == 8'd5);
      if (local_id && md[108] && m_drop_en) begin
         m_drop_pkt  = m_drop_pkt + 64'd1;
         m_drop_byte = m_drop_byte + {52'd0, md[107:96]};
      end else begin
         p.md  = md;
         p.phv = phv;
         if (local_id) p.md[87:80] = 8'd6;
         exp_pairs.push_back(p);
         m_fwd_pkt = m_fwd_pkt + 64'd1;
      end
      @(negedge clk);
      in_dcm_md     = md;
      in_dcm_phv    = phv;
      in_dcm_md_wr  = 1'b1;
      in_dcm_phv_wr = 1'b1;
      @(negedge clk);
      in_dcm_md_wr  = 1'b0;
      in_dcm_phv_wr = 1'b0;
   endtask

   task automatic cfgAccess(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data, input logic ready);
      logic [159:0] raw;
      logic [133:0] w;
      raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      w = raw[133:0];
      w[126:124] = typ;
      w[95:64]   = addr;
      w[31:0]    = data;
      if (ready) begin
         if (typ == T_RD) exp_cfg.push_back({w[133:128], 4'b1011, w[123:32], modelRead(addr)});
         else             exp_cfg.push_back(w);
         if (typ == T_WR && addr == A_CTRL) begin
            m_drop_en = data[1];
            if (data[0]) begin
               m_drop_pkt  = '0;
               m_drop_byte = '0;
               m_fwd_pkt   = '0;
            end
         end
      end
      @(negedge clk);
      cin_dcm_data    = w;
      cin_dcm_data_wr = 1'b1;
      cin_dcm_ready   = ready;
      #1;
      checkOutput("cout_ready", 256'(cout_dcm_ready), 256'(ready));
      @(negedge clk);
      cin_dcm_data_wr = 1'b0;
      cin_dcm_ready   = 1'b1;
      checkOutput("cfg_latency", 256'(cout_dcm_data_wr), 256'(ready));
   endtask

   task automatic drainCheck(input int cycles);
      repeat (cycles) @(negedge clk);
      checkOutput("drain_pairs", 256'(exp_pairs.size()), 256'd0);
      checkOutput("drain_cfg", 256'(exp_cfg.size()), 256'd0);
   endtask

   task automatic doReset();
      rst_n           = 1'b0;
      in_dcm_md       = '0;
      in_dcm_md_wr    = 1'b0;
      in_dcm_phv      = '0;
      in_dcm_phv_wr   = 1'b0;
      in_dcm_md_alf   = 1'b0;
      in_dcm_phv_alf  = 1'b0;
      cin_dcm_data    = '0;
      cin_dcm_data_wr = 1'b0;
      cin_dcm_ready   = 1'b1;
      m_drop_en       = 1'b1;
      m_drop_pkt      = '0;
      m_drop_byte     = '0;
      m_fwd_pkt       = '0;
      repeat (4) @(negedge clk);
      checkOutput("rst_out_md", out_dcm_md, 256'd0);
      checkOutput("rst_out_phv", out_dcm_phv[255:0], 256'd0);
      checkOutput("rst_wr", 256'({out_dcm_md_wr, out_dcm_phv_wr, cout_dcm_data_wr}), 256'd0);
      checkOutput("rst_cout", 256'(cout_dcm_data), 256'd0);
      checkOutput("rst_alf", 256'({out_dcm_md_alf, out_dcm_phv_alf}), 256'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Monitor: every presented output is matched against the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_dcm_md_wr || out_dcm_phv_wr) begin
            checkOutput("wr_align", 256'(out_dcm_phv_wr), 256'(out_dcm_md_wr));
            if (exp_pairs.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_pair actual=%0h required=none", out_dcm_md);
            end else begin
               mon_pair = exp_pairs.pop_front();
               checkOutput("pair_md", out_dcm_md, mon_pair.md);
               for (int k = 0; k < 4; k++)
                  checkOutput($sformatf("pair_phv%0d", k), out_dcm_phv[k*256 +: 256], mon_pair.phv[k*256 +: 256]);
            end
         end
         if (cout_dcm_data_wr) begin
            if (exp_cfg.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_cfg actual=%0h required=none", cout_dcm_data);
            end else begin
               mon_cfg = exp_cfg.pop_front();
               checkOutput("cfg_word", 256'(cout_dcm_data), 256'(mon_cfg));
            end
         end
      end
   end

   initial begin
      int lat;
      int held_wr;
      int wr_seen;
      int wr_at[5];
      logic [7:0] rid;

      $display("[TB] dcm bench start");
      doReset();
      cfgAccess(T_RD, A_CTRL, 32'd0, 1'b1);

      // Bypass pair with latency measured from the FIFO write.
      applyStimulus(makeMd(8'd3, 1'b0, 12'd40), 1024'hA5);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_dcm_md_wr && lat == 0) lat = k;
      end
      checkOutput("bypass_latency", 256'(lat), 256'd2);
      cfgAccess(T_RD, A_FPLO, 32'd0, 1'b1);

      applyStimulus(makeMd(8'd5, 1'b0, 12'd64), randPhv());
      for (int i = 0; i < 3; i++) applyStimulus(makeMd(8'd5, 1'b1, 12'd100), randPhv());
      drainCheck(8);
      cfgAccess(T_RD, A_DPLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_DBLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_DPHI, 32'd0, 1'b1);

      // With drop_en cleared a flagged local pair is forwarded.
      cfgAccess(T_WR, A_CTRL, 32'd0, 1'b1);
      applyStimulus(makeMd(8'd5, 1'b1, 12'd77), randPhv());
      drainCheck(8);
      cfgAccess(T_RD, A_DPLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_CTRL, 32'd0, 1'b1);
      cfgAccess(T_WR, A_CTRL, 32'd2, 1'b1);

      // Backpressure: queue five pairs while held, then release.
      in_dcm_md_alf = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(makeMd((i % 2 == 0) ? 8'd3 : 8'd5, 1'b0, 12'(i)), randPhv());
      held_wr = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_dcm_md_wr) held_wr++;
      end
      checkOutput("held_writes", 256'(held_wr), 256'd0);
      checkOutput("alf_passthru", 256'(out_dcm_md_alf), 256'd1);
      in_dcm_md_alf = 1'b0;
      wr_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_dcm_md_wr && wr_seen < 5) begin
            wr_at[wr_seen] = k;
            wr_seen++;
         end
      end
      checkOutput("bp_writes", 256'(wr_seen), 256'd5);
      for (int i = 1; i < 5; i++) checkOutput("bp_spacing", 256'(wr_at[i] - wr_at[i-1]), 256'd2);

      // Randomized traffic with drop_en randomly toggled between batches.
      for (int b = 0; b < 3; b++) begin
         cfgAccess(T_WR, A_CTRL, {30'd0, 1'($urandom_range(0, 1)), 1'b0}, 1'b1);
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
               0:       rid = 8'd3;
               1:       rid = 8'd5;
               default: rid = 8'($urandom());
            endcase
            applyStimulus(makeMd(rid, 1'($urandom_range(0, 1)), 12'($urandom())), randPhv());
         end
         drainCheck(10);
      end
      cfgAccess(T_RD, A_DPLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_DBLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_FPLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_FPHI, 32'd0, 1'b1);
      cfgAccess(T_RD, A_DBHI, 32'd0, 1'b1);

      // Config pass-through cases: unmapped read, foreign write, other type, not ready.
      cfgAccess(T_RD, 32'h7100_0005, 32'hDEAD_BEEF, 1'b1);
      cfgAccess(T_WR, 32'h1234_5678, 32'hCAFE_0001, 1'b1);
      cfgAccess(3'b000, A_CTRL, 32'h0000_0001, 1'b1);
      cfgAccess(T_RD, A_CTRL, 32'd0, 1'b0);
      drainCheck(4);

      // Almost-full from FIFO level: MD words only, so nothing drains.
      @(negedge clk);
      in_dcm_md    = makeMd(8'd3, 1'b0, 12'd1);
      in_dcm_md_wr = 1'b1;
      repeat (250) @(negedge clk);
      checkOutput("alf_at_250", 256'(out_dcm_md_alf), 256'd0);
      @(negedge clk);
      in_dcm_md_wr = 1'b0;
      checkOutput("alf_at_251", 256'(out_dcm_md_alf), 256'd1);
      checkOutput("phv_alf_low", 256'(out_dcm_phv_alf), 256'd0);
      doReset();

      // Clear written in the very cycle the drop counter would increment.
      applyStimulus(makeMd(8'd5, 1'b1, 12'd100), randPhv());
      cfgAccess(T_WR, A_CTRL, 32'd3, 1'b1);
      drainCheck(6);
      cfgAccess(T_RD, A_DPLO, 32'd0, 1'b1);
      cfgAccess(T_RD, A_DBLO, 32'd0, 1'b1);
      applyStimulus(makeMd(8'd9, 1'b1, 12'd5), randPhv());
      drainCheck(8);
      cfgAccess(T_RD, A_FPLO, 32'd0, 1'b1);
      drainCheck(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
